// File: rtl/alu_serial_ctrl_if.sv
// Interface between a requester, alu_serial_ctrl and the downstream 1-bit ALU.
// The optional zero flag is present only when ALU_SERIAL_ZERO_FLAG_EN is defined.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op_select;
  logic             op_mode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       alu_select;
  logic             alu_mode;
  logic             alu_a;
  logic             alu_b;
  logic             alu_out;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             zero;
`endif

  modport slave (
    input  start, op_select, op_mode, operand_a, operand_b, alu_out,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output zero,
`endif
    output busy, done, result, alu_select, alu_mode, alu_a, alu_b
  );

  modport master (
    output start, op_select, op_mode, operand_a, operand_b, alu_out,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    input  zero,
`endif
    input  busy, done, result, alu_select, alu_mode, alu_a, alu_b
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer feeding a 1-bit ALU LSB first and reassembling its output.
// Optional zero flag: define ALU_SERIAL_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start; operands and opcode latched on start
// SHIFT | one bit pair presented per clock, ALU output shifted into result
// DONE  | one-cycle done pulse, result valid; start ignored
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  alu_serial_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r, result_q;
  logic [CW-1:0]    cnt;
  logic [1:0]       sel_q;
  logic             mode_q;
  logic             last;

  assign last           = (cnt == CW'(WIDTH - 1));
  assign bus.result     = result_q;
  assign bus.alu_select = sel_q;
  assign bus.alu_mode   = mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.alu_a = 1'b0;
    bus.alu_b = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = SHIFT;
      SHIFT: begin
        bus.busy  = 1'b1;
        bus.alu_a = sh_a[0];
        bus.alu_b = sh_b[0];
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      result_q <= '0;
      cnt      <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sh_a   <= bus.operand_a;
          sh_b   <= bus.operand_b;
          sel_q  <= bus.op_select;
          mode_q <= bus.op_mode;
          cnt    <= '0;
        end
        SHIFT: begin
          sh_r <= {bus.alu_out, sh_r[WIDTH-1:1]};
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          if (last) begin
            // final bit goes straight into result so it is complete on DONE entry
            result_q <= {bus.alu_out, sh_r[WIDTH-1:1]};
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic any_one;
  logic zero_q;

  assign bus.zero = zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_one <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        any_one <= 1'b0;
      end else if (state == SHIFT) begin
        any_one <= any_one | bus.alu_out;
        if (last) zero_q <= ~(any_one | bus.alu_out);
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a behavioural 1-bit ALU attached.
// Zero-flag checks are compiled in when ALU_SERIAL_ZERO_FLAG_EN is defined.
module tb_alu_serial_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cycle;
  logic [W-1:0] prev_result;

  alu_serial_ctrl_if #(.WIDTH(W)) bus_if ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // 1-bit ALU: 00 pass, 01 invert, 10 xor, 11 xnor; mode picks B for 00/01
  function automatic logic alu_bit(input logic [1:0] s, input logic m, input logic a, input logic b);
    case (s)
      2'b00:   return m ? b : a;
      2'b01:   return m ? ~b : ~a;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [1:0] s, input logic m,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      2'b00:   return m ? b : a;
      2'b01:   return m ? ~b : ~a;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign bus_if.alu_out = alu_bit(bus_if.alu_select, bus_if.alu_mode, bus_if.alu_a, bus_if.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op_select = 2'b00;
    bus_if.op_mode = 1'b0;
    bus_if.operand_a = '0;
    bus_if.operand_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.alu_a, bus_if.alu_b, bus_if.alu_mode} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/alu_a/alu_b/alu_mode=%b required 00000",
               {bus_if.busy, bus_if.done, bus_if.alu_a, bus_if.alu_b, bus_if.alu_mode});
    end
    n_checks++;
    if (bus_if.result !== '0 || bus_if.alu_select !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: result=%h alu_select=%b required 00/00", bus_if.result, bus_if.alu_select);
    end
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    n_checks++;
    if (bus_if.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_zero: zero=%b required 0", bus_if.zero);
    end
`endif
    rst = 1'b0;
    prev_result = '0;
    @(negedge clk);
  endtask

  // one full operation from start to return to IDLE; glitch_k >= 0 pulses start
  // with A=FF during shift cycle glitch_k, which must be ignored
  task automatic do_op(input string name, input logic [1:0] sel, input logic mode,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_k);
    logic [W-1:0] exp;
    exp = ref_word(sel, mode, a, b);
    bus_if.op_select = sel;
    bus_if.op_mode   = mode;
    bus_if.operand_a = a;
    bus_if.operand_b = b;
    bus_if.start     = 1'b1;
    @(posedge clk);
    #1 bus_if.start  = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (k == glitch_k) begin
        bus_if.start = 1'b1;
        bus_if.operand_a = 8'hFF;
        bus_if.op_select = ~sel;
      end else if (k == glitch_k + 1) begin
        bus_if.start = 1'b0;
      end
      n_checks++;
      if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s shift_ctl k=%0d: busy=%b done=%b required 1 0", name, k, bus_if.busy, bus_if.done);
      end
      n_checks++;
      if (bus_if.alu_a !== a[k] || bus_if.alu_b !== b[k] || bus_if.alu_select !== sel
          || bus_if.alu_mode !== mode) begin
        n_fail++;
        $display("FAIL %s alu_drive k=%0d: a=%b b=%b sel=%b mode=%b required %b %b %b %b", name, k,
                 bus_if.alu_a, bus_if.alu_b, bus_if.alu_select, bus_if.alu_mode, a[k], b[k], sel, mode);
      end
      n_checks++;
      if (bus_if.result !== prev_result) begin
        n_fail++;
        $display("FAIL %s result_hold k=%0d: result=%h required %h", name, k, bus_if.result, prev_result);
      end
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    n_checks++;
    if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b1 || bus_if.alu_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle: done=%b busy=%b alu_a=%b required 1 1 0", name,
               bus_if.done, bus_if.busy, bus_if.alu_a);
    end
    n_checks++;
    if (bus_if.result !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h required %h", name, bus_if.result, exp);
    end
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    n_checks++;
    if (bus_if.zero !== (exp == '0)) begin
      n_fail++;
      $display("FAIL %s zero: got %b required %b", name, bus_if.zero, (exp == '0));
    end
`endif
    @(negedge clk);
    n_checks++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.alu_select !== sel
        || bus_if.result !== exp) begin
      n_fail++;
      $display("FAIL %s idle_after: done=%b busy=%b sel=%b result=%h required 0 0 %b %h", name,
               bus_if.done, bus_if.busy, bus_if.alu_select, bus_if.result, sel, exp);
    end
    prev_result = exp;
  endtask

  task automatic test_directed();
    do_op("pass_a5", 2'b00, 1'b0, 8'hA5, 8'h00, -10);
    do_op("inv_a5", 2'b01, 1'b0, 8'hA5, 8'h00, -10);
    do_op("xor_3c0f", 2'b10, 1'b0, 8'h3C, 8'h0F, -10);
    do_op("xnor_m0", 2'b11, 1'b0, 8'h3C, 8'h0F, -10);
    do_op("xnor_m1", 2'b11, 1'b1, 8'h3C, 8'h0F, -10);
  endtask

  task automatic test_start_while_busy();
    do_op("busy_start", 2'b00, 1'b0, 8'hA5, 8'h00, 2);
  endtask

  task automatic test_reset_mid_op();
    int dones;
    bus_if.op_select = 2'b00;
    bus_if.op_mode   = 1'b0;
    bus_if.operand_a = 8'hFF;
    bus_if.operand_b = 8'hFF;
    bus_if.start     = 1'b1;
    @(posedge clk);
    #1 bus_if.start  = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus_if.busy !== 1'b0 || bus_if.alu_a !== 1'b0 || bus_if.done !== 1'b0
        || bus_if.result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b alu_a=%b done=%b result=%h required 0 0 0 00",
               bus_if.busy, bus_if.alu_a, bus_if.done, bus_if.result);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_result = '0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulses=%0d required 0", dones);
    end
    do_op("after_reset", 2'b10, 1'b0, 8'h5C, 8'hC3, -10);
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    logic [W-1:0] exp;
    exp = ref_word(2'b01, 1'b1, 8'h12, 8'h6B);
    bus_if.op_select = 2'b01;
    bus_if.op_mode   = 1'b1;
    bus_if.operand_a = 8'h12;
    bus_if.operand_b = 8'h6B;
    bus_if.start     = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) begin
        done_cyc.push_back(cycle);
        n_checks++;
        if (bus_if.result !== exp) begin
          n_fail++;
          $display("FAIL b2b_result: got %h required %h", bus_if.result, exp);
        end
      end
    end
    bus_if.start = 1'b0;
    n_checks++;
    if (done_cyc.size() < 4) begin
      n_fail++;
      $display("FAIL b2b_count: done pulses=%0d required >=4", done_cyc.size());
    end
    for (int i = 1; i < done_cyc.size(); i++) begin
      n_checks++;
      if (done_cyc[i] - done_cyc[i-1] !== W + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d cycles required %0d", done_cyc[i] - done_cyc[i-1], W + 2);
      end
    end
    repeat (W + 3) @(negedge clk);
    prev_result = exp;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), -10);
    end
  endtask

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  task automatic test_zero_flag();
    do_op("zero_set", 2'b10, 1'b0, 8'h77, 8'h77, -10);
    do_op("zero_clr", 2'b00, 1'b0, 8'h01, 8'h00, -10);
    do_op("zero_msb", 2'b00, 1'b0, 8'h80, 8'h00, -10);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cycle    = 0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
